// File: rtl/linear_layer_start_fifo_srl_pkg.sv
// Shared constants for the start-token / stream FIFO between the producer and
// the PE_i4xi4_pack_2x2 stage.
package linear_layer_start_fifo_srl_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 1;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 4;
  localparam int unsigned DEFAULT_DEPTH      = 16;

  // The occupancy counter needs one extra bit so it can hold DEPTH itself.
  function automatic int unsigned count_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/linear_layer_start_fifo_srl_if.sv
// Write/read handshake bundle of the SRL FIFO.
//   master : producer + consumer side (drives requests, data in)
//   slave  : FIFO side (drives flags, data out, occupancy, capacity)
interface linear_layer_start_fifo_srl_if
  import linear_layer_start_fifo_srl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  localparam int unsigned CW = count_width(ADDR_WIDTH);

  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_full_n;
  logic                  if_read_ce;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_empty_n;
  logic [CW-1:0]         if_num_data_valid;
  logic [CW-1:0]         if_fifo_cap;

  modport master (
    output if_write_ce, if_write, if_din, if_read_ce, if_read,
    input  if_full_n, if_dout, if_empty_n, if_num_data_valid, if_fifo_cap
  );

  modport slave (
    input  if_write_ce, if_write, if_din, if_read_ce, if_read,
    output if_full_n, if_dout, if_empty_n, if_num_data_valid, if_fifo_cap
  );

endinterface

// File: rtl/linear_layer_start_fifo_srl_shiftreg.sv
// Fixed-tap shift-register array. Shifts on we (tap i -> i+1, din -> tap 0);
// dout is a combinational read of tap addr. No reset: contents are only
// meaningful where the control logic says they are.
// Ports: clk, we, addr, din, dout.
module linear_layer_start_fifo_srl_shiftreg
  import linear_layer_start_fifo_srl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] taps [DEPTH];

  // Shift chain
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = int'(DEPTH) - 1; i > 0; i--) begin
        taps[i] <= taps[i-1];
      end
      taps[0] <= din;
    end
  end

  // Tap select; addresses beyond DEPTH only occur when the FIFO is empty.
  always_comb begin
    dout = '0;
    if (32'(addr) < DEPTH) dout = taps[addr];
  end

endmodule

// File: rtl/linear_layer_start_fifo_srl.sv
// SRL FIFO: occupancy counter and registered full/empty flags around a
// shift-register array; the oldest entry sits at tap count-1.
// Ports: clk, reset (sync, active-high), bus (slave modport: write/read
// handshakes, din/dout, if_num_data_valid, if_fifo_cap).
module linear_layer_start_fifo_srl
  import linear_layer_start_fifo_srl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  linear_layer_start_fifo_srl_if.slave bus
);

  localparam int unsigned CW = count_width(ADDR_WIDTH);

  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // Registered flags block write-through when full and read-through when empty.
  assign push = bus.if_write & bus.if_write_ce & bus.if_full_n;
  assign pop  = bus.if_read  & bus.if_read_ce  & bus.if_empty_n;

  // Next occupancy
  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CW'(1);
    else if (!push && pop) count_next = count - CW'(1);
  end

  // Counter and flags, both derived from the next count
  always_ff @(posedge clk) begin
    if (reset) begin
      count          <= '0;
      bus.if_full_n  <= 1'b1;
      bus.if_empty_n <= 1'b0;
    end else begin
      count          <= count_next;
      bus.if_full_n  <= (count_next != CW'(DEPTH));
      bus.if_empty_n <= (count_next != CW'(0));
    end
  end

  assign rd_addr               = ADDR_WIDTH'(count - CW'(1));
  assign bus.if_num_data_valid = count;
  assign bus.if_fifo_cap       = CW'(DEPTH);

  linear_layer_start_fifo_srl_shiftreg #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_shiftreg (
    .clk  (clk),
    .we   (push),
    .addr (rd_addr),
    .din  (bus.if_din),
    .dout (bus.if_dout)
  );

endmodule

// File: tb/tb_linear_layer_start_fifo_srl.sv
module tb_linear_layer_start_fifo_srl;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int DEP = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  linear_layer_start_fifo_srl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  linear_layer_start_fifo_srl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Reference model: a plain queue of entries, oldest at the front.
  logic [DW-1:0] q[$];
  bit            model_ok = 0;

  always @(posedge clk) begin
    bit do_push, do_pop;
    if (reset) begin
      q.delete();
      model_ok = 1;
    end else begin
      do_push = bus.if_write && bus.if_write_ce && (q.size() < DEP);
      do_pop  = bus.if_read  && bus.if_read_ce  && (q.size() > 0);
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(bus.if_din);
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (model_ok) begin
      check("cyc_count", int'(bus.if_num_data_valid), q.size());
      check("cyc_full_n", int'(bus.if_full_n), int'(q.size() != DEP));
      check("cyc_empty_n", int'(bus.if_empty_n), int'(q.size() != 0));
      check("cyc_cap", int'(bus.if_fifo_cap), DEP);
      if (q.size() > 0) check("cyc_dout", int'(bus.if_dout), int'(q[0]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_write = 1'b0;
    bus.if_read  = 1'b0;
  endtask

  task automatic push_one(input logic [DW-1:0] d);
    bus.if_write = 1'b1;
    bus.if_read  = 1'b0;
    bus.if_din   = d;
    step();
    idle();
  endtask

  task automatic pop_expect(input string name, input int d);
    check(name, int'(bus.if_dout), d);
    bus.if_read  = 1'b1;
    bus.if_write = 1'b0;
    step();
    idle();
  endtask

  initial begin
    reset           = 1'b1;
    bus.if_write_ce = 1'b1;
    bus.if_read_ce  = 1'b1;
    bus.if_write    = 1'b0;
    bus.if_read     = 1'b0;
    bus.if_din      = '0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_full_n", int'(bus.if_full_n), 1);
    check("rst_empty_n", int'(bus.if_empty_n), 0);
    check("rst_count", int'(bus.if_num_data_valid), 0);
    check("rst_cap", int'(bus.if_fifo_cap), 16);
    step();

    // Three pushes then three pops
    push_one(8'h11);
    check("lat_empty_n", int'(bus.if_empty_n), 1);
    check("lat_dout", int'(bus.if_dout), 'h11);
    push_one(8'h22);
    push_one(8'h33);
    check("three_count", int'(bus.if_num_data_valid), 3);
    pop_expect("three_d0", 'h11);
    pop_expect("three_d1", 'h22);
    check("three_empty_mid", int'(bus.if_empty_n), 1);
    pop_expect("three_d2", 'h33);
    check("three_empty_n", int'(bus.if_empty_n), 0);
    check("three_count0", int'(bus.if_num_data_valid), 0);

    // Fill to 16, dropped 17th write, drain
    for (int i = 0; i < 16; i++) begin
      check("fill_full_n_pre", int'(bus.if_full_n), 1);
      push_one(8'(i));
    end
    check("fill_full_n", int'(bus.if_full_n), 0);
    check("fill_count", int'(bus.if_num_data_valid), 16);
    push_one(8'hAA);
    check("drop_count", int'(bus.if_num_data_valid), 16);
    for (int i = 0; i < 16; i++) pop_expect("drain_data", i);
    check("drain_empty_n", int'(bus.if_empty_n), 0);

    // Preload 4, then 10 cycles of simultaneous push/pop
    for (int i = 0; i < 4; i++) push_one(8'h30 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      check("stream_dout", int'(bus.if_dout), (i < 4) ? ('h30 + i) : ('h40 + i - 4));
      bus.if_write = 1'b1;
      bus.if_read  = 1'b1;
      bus.if_din   = 8'h40 + 8'(i);
      step();
      check("stream_count", int'(bus.if_num_data_valid), 4);
    end
    idle();
    for (int i = 6; i < 10; i++) pop_expect("stream_tail", 'h40 + i);

    // Full with simultaneous write+read: only the pop happens
    for (int i = 0; i < 16; i++) push_one(8'h50 + 8'(i));
    bus.if_write = 1'b1;
    bus.if_read  = 1'b1;
    bus.if_din   = 8'hBB;
    step();
    idle();
    check("full_rw_count", int'(bus.if_num_data_valid), 15);
    check("full_rw_full_n", int'(bus.if_full_n), 1);
    for (int i = 1; i < 16; i++) pop_expect("full_rw_drain", 'h50 + i);

    // Empty with simultaneous write+read: only the push happens
    bus.if_write = 1'b1;
    bus.if_read  = 1'b1;
    bus.if_din   = 8'hCC;
    step();
    idle();
    check("empty_rw_count", int'(bus.if_num_data_valid), 1);
    check("empty_rw_dout", int'(bus.if_dout), 'hCC);
    pop_expect("empty_rw_pop", 'hCC);

    // Mid-operation reset with a write pending
    for (int i = 0; i < 7; i++) push_one(8'h60 + 8'(i));
    reset        = 1'b1;
    bus.if_write = 1'b1;
    bus.if_din   = 8'hDD;
    step();
    reset = 1'b0;
    idle();
    check("mrst_count", int'(bus.if_num_data_valid), 0);
    check("mrst_empty_n", int'(bus.if_empty_n), 0);
    check("mrst_full_n", int'(bus.if_full_n), 1);
    step();
    check("mrst_not_kept", int'(bus.if_num_data_valid), 0);

    // Clock enables freeze their side only
    bus.if_write_ce = 1'b0;
    push_one(8'hEE);
    check("wce_count", int'(bus.if_num_data_valid), 0);
    check("wce_empty_n", int'(bus.if_empty_n), 0);
    bus.if_write_ce = 1'b1;
    push_one(8'h77);
    bus.if_read_ce = 1'b0;
    bus.if_read    = 1'b1;
    step();
    idle();
    check("rce_count", int'(bus.if_num_data_valid), 1);
    bus.if_read_ce = 1'b1;
    pop_expect("rce_pop", 'h77);
    check("rce_empty", int'(bus.if_num_data_valid), 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
